op_sequencer: RTL and testbench
===============================

Name: op_sequencer

Overview:
- Controller that shares one start/endd/er/stop-style processing engine between NUM_REQ requesters.
- Arbitrates requests round-robin and sequences each operation through start, run, optional stop, and completion.
- Reports the result per requester (ack) and globally (status_valid, status, interrupt).
- Sits between the requesters and the engine; it is the only block allowed to drive the engine's start and stop.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TIMEOUT, 64, maximum RUN cycles before forced stop (>= 2).
- CNT_W, $clog2(TIMEOUT), RUN timer width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- req  in  NUM_REQ  level request per requester.
- abort  in  1  software abort of the current operation.
- endd  in  1  engine: operation finished OK.
- er  in  1  engine: operation failed.
- start  out  1  engine start, 1-cycle pulse.
- stop  out  1  engine stop, 1-cycle pulse.
- rdy  out  1  sequencer idle and accepting.
- ack  out  NUM_REQ  one-hot completion pulse to the granted requester.
- gnt_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- status_valid  out  1  1-cycle pulse qualifying status.
- status  out  2  result code, held until the next status_valid.
- interrupt  out  1  1-cycle pulse on a non-OK result.

Behaviour:
- All outputs are registered.
- Reset values: rdy=1; start, stop, ack, status_valid, interrupt = 0; status=OK; gnt_id=0; RR pointer=0; state=IDLE; timer=0.

States:
- IDLE: rdy=1. If any req bit is set, pick the first set bit searching upward from the pointer, with wrap. Latch it into gnt_id and go to START. Otherwise stay.
- START: start=1 and rdy=0 for exactly this cycle. Timer cleared. Next state RUN.
- RUN: timer increments each cycle. Exit priority, evaluated each cycle:
  - er -> DONE, status=ERR.
  - endd -> DONE, status=OK.
  - abort -> STOP, status=ABORT.
  - timer == TIMEOUT-1 -> STOP, status=TIMEOUT.
- STOP: stop=1 for exactly this cycle. Next state DONE.
- DONE: ack[gnt_id]=1, status_valid=1, status updated, interrupt = (status != OK). Pointer = gnt_id+1 mod NUM_REQ. Next state IDLE.

Latency:
- req seen in IDLE at cycle t -> start high at t+1 -> RUN from t+2.
- endd/er in RUN at cycle u -> ack/status_valid at u+1.
- Timeout with no endd/er/abort: stop at t+2+TIMEOUT, ack at t+3+TIMEOUT.

Invariants:
- start and stop are never high together.
- rdy=0 from START through DONE inclusive.
- At most one ack bit is high.
- status_valid and ack are coincident.
- interrupt implies status_valid.

Boundary conditions:
- endd and er in the same cycle: ERR wins.
- endd/er together with abort or timeout: engine result wins and no stop is issued.
- endd, er and abort outside RUN are ignored, including during START.
- req withdrawn after grant: the operation still completes and ack is still pulsed.
- req held high after its ack: it is re-arbitrated behind other pending requesters; it does not win twice in a row if others are pending.
- Single requester continuously requesting: back-to-back operations with one IDLE cycle between them (rdy high for 1 cycle).
- Reset mid-operation: immediate return to reset values, no stop/ack/interrupt emitted. The engine shares the same rst.
- Timer never wraps; the exit at TIMEOUT-1 is mandatory.

Decomposition:
- Package op_seq_pkg holds:
  - state_t enum {IDLE, START, RUN, STOP, DONE}.
  - status_t 2-bit enum {ST_OK=0, ST_ERR=1, ST_TIMEOUT=2, ST_ABORT=3}.
- Sub-module rr_arbiter:
  - Inputs: req vector and pointer. Outputs: valid and index.
  - Combinational rotate-and-priority-encode, parameterised by NUM_REQ.
- op_sequencer holds the FSM, timer, pointer and output registers.

Test Plan:
- After rst release, req=4'b0100 at cycle 0 -> start at cycle 1, gnt_id=2, rdy=0. endd at cycle 5 -> ack=4'b0100, status_valid=1, status=OK, interrupt=0 at cycle 6, rdy=1 at cycle 7.
- req=4'b1111 held, endd returned 3 cycles after each start -> grant order 0,1,2,3,0. Exactly one ack bit per operation.
- TIMEOUT=8, req=4'b0001, engine silent -> stop pulse exactly 8 cycles after the first RUN cycle. Next cycle: ack=4'b0001, status=TIMEOUT, interrupt=1.
- endd and er high together in RUN -> status=ERR, interrupt=1, stop never asserted.
- abort in the 2nd RUN cycle -> stop next cycle, then status=ABORT and interrupt=1. abort pulsed while IDLE -> no effect.
- rst driven low during RUN -> all outputs at reset values in the same cycle, no ack. After release, pending req=4'b0010 is granted with gnt_id=1 (pointer back at 0).

Source files
------------

// File: rtl/op_seq_pkg.sv
// ---------------------------------------------------------------------------
// op_seq_pkg
// Shared types for the operation sequencer:
//   state_t  - sequencer FSM states
//   status_t - result code reported on status
//   is_fail  - helper telling whether a result code raises an interrupt
// ---------------------------------------------------------------------------
package op_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ERR     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ABORT   = 2'd3
  } status_t;

  // Any result other than OK is reported through interrupt.
  function automatic logic is_fail(input status_t s);
    return (s != ST_OK);
  endfunction

endpackage

// File: rtl/op_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin selector: finds the first set request bit
// searching upward from ptr with wrap-around.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    search start position (0..NUM_REQ-1)
//   valid out 1        at least one request is set
//   idx   out IDX_W    index of the selected request
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] pos_s;

  // Rotate-and-priority-encode: walk offsets from farthest to nearest so the
  // request closest to ptr is the last (winning) assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum_s = '0;
    pos_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s = {1'b0, ptr} + (IDX_W + 1)'(i);
      pos_s = (sum_s >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum_s - (IDX_W + 1)'(NUM_REQ))
                                               : sum_s[IDX_W-1:0];
      idx   = req[pos_s] ? pos_s : idx;
      valid = valid | req[pos_s];
    end
  end

endmodule

// File: rtl/op_sequencer.sv
// ---------------------------------------------------------------------------
// op_sequencer
// Shares one start/stop style engine between NUM_REQ requesters. Requests
// are granted round-robin; each operation goes START -> RUN -> (STOP) ->
// DONE and its result is reported per requester (ack) and globally
// (status_valid / status / interrupt). All outputs are registered: each
// output register is loaded from the next-state decision so it is valid in
// the same cycle the FSM occupies the matching state.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   req          in   level request per requester
//   abort        in   software abort of the running operation
//   endd / er    in   engine finished OK / failed
//   start / stop out  1-cycle engine control pulses
//   rdy          out  sequencer idle
//   ack          out  one-hot completion pulse to the granted requester
//   gnt_id       out  current / last granted requester
//   status_valid out  1-cycle pulse qualifying status
//   status       out  result code, held until the next status_valid
//   interrupt    out  1-cycle pulse on a non-OK result
// ---------------------------------------------------------------------------
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               abort,
  input  logic               endd,
  input  logic               er,
  output logic               start,
  output logic               stop,
  output logic               rdy,
  output logic [NUM_REQ-1:0] ack,
  output logic [IDX_W-1:0]   gnt_id,
  output logic               status_valid,
  output logic [1:0]         status,
  output logic               interrupt
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t               state_r;
  state_t               state_nxt_s;
  status_t              res_r;
  status_t              res_nxt_s;
  status_t              status_r;
  logic [CNT_W-1:0]     timer_r;
  logic [IDX_W-1:0]     ptr_r;
  logic [IDX_W-1:0]     gnt_id_r;
  logic [IDX_W-1:0]     arb_idx_s;
  logic                 arb_valid_s;
  logic                 start_r;
  logic                 stop_r;
  logic                 rdy_r;
  logic [NUM_REQ-1:0]   ack_r;
  logic                 status_valid_r;
  logic                 interrupt_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .valid (arb_valid_s),
    .idx   (arb_idx_s)
  );

  // Next-state and pending-result decision; engine inputs only matter in RUN.
  always_comb begin
    state_nxt_s = state_r;
    res_nxt_s   = res_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        state_nxt_s = RUN;
      end
      RUN: begin
        // Engine result outranks abort/timeout, and goes straight to DONE
        // so no stop pulse is issued for a finished operation.
        if (er) begin
          state_nxt_s = DONE;
          res_nxt_s   = ST_ERR;
        end else if (endd) begin
          state_nxt_s = DONE;
          res_nxt_s   = ST_OK;
        end else if (abort) begin
          state_nxt_s = STOP;
          res_nxt_s   = ST_ABORT;
        end else if (timer_r == TMO_LAST) begin
          state_nxt_s = STOP;
          res_nxt_s   = ST_TIMEOUT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STOP: begin
        state_nxt_s = DONE;
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        res_nxt_s   = ST_OK;
      end
    endcase
  end

  // State, timer, pointer, grant and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      res_r          <= ST_OK;
      status_r       <= ST_OK;
      timer_r        <= '0;
      ptr_r          <= '0;
      gnt_id_r       <= '0;
      start_r        <= 1'b0;
      stop_r         <= 1'b0;
      rdy_r          <= 1'b1;
      ack_r          <= '0;
      status_valid_r <= 1'b0;
      interrupt_r    <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      res_r          <= res_nxt_s;
      start_r        <= (state_nxt_s == START);
      stop_r         <= (state_nxt_s == STOP);
      rdy_r          <= (state_nxt_s == IDLE);
      status_valid_r <= (state_nxt_s == DONE);

      if (state_nxt_s == DONE) begin
        ack_r       <= {{(NUM_REQ - 1){1'b0}}, 1'b1} << gnt_id_r;
        status_r    <= res_nxt_s;
        interrupt_r <= is_fail(res_nxt_s);
      end else begin
        ack_r       <= '0;
        interrupt_r <= 1'b0;
      end

      // Timer only advances while staying in RUN, so it never wraps.
      if (state_r == START) begin
        timer_r <= '0;
      end else if ((state_r == RUN) && (state_nxt_s == RUN)) begin
        timer_r <= timer_r + CNT_W'(1);
      end else begin
        timer_r <= timer_r;
      end

      if ((state_r == IDLE) && arb_valid_s) begin
        gnt_id_r <= arb_idx_s;
      end else begin
        gnt_id_r <= gnt_id_r;
      end

      // The just-served requester moves to the back of the rotation.
      if (state_r == DONE) begin
        ptr_r <= (gnt_id_r == LAST_IDX) ? '0 : gnt_id_r + IDX_W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  assign start        = start_r;
  assign stop         = stop_r;
  assign rdy          = rdy_r;
  assign ack          = ack_r;
  assign gnt_id       = gnt_id_r;
  assign status_valid = status_valid_r;
  assign status       = status_r;
  assign interrupt    = interrupt_r;

endmodule

// File: tb/tb_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_op_sequencer
// Self-checking bench for op_sequencer (NUM_REQ=4, TIMEOUT=8). Inputs are
// driven and outputs sampled on the falling clock edge. Expected grants come
// from a round-robin search over a model pointer; expected status, stop
// presence and latency come from the operation kind.
// Operation kinds: 0 endd, 1 er, 2 endd+er, 3 abort, 4 timeout,
//                  5 endd+abort, 6 er+abort
// ---------------------------------------------------------------------------
module tb_op_sequencer;

  localparam int N = 4;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         abort = 1'b0;
  logic         endd = 1'b0;
  logic         er = 1'b0;
  logic         start;
  logic         stop;
  logic         rdy;
  logic [N-1:0] ack;
  logic [1:0]   gnt_id;
  logic         status_valid;
  logic [1:0]   status;
  logic         interrupt;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;

  op_sequencer #(.NUM_REQ(N), .TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .abort        (abort),
    .endd         (endd),
    .er           (er),
    .start        (start),
    .stop         (stop),
    .rdy          (rdy),
    .ack          (ack),
    .gnt_id       (gnt_id),
    .status_valid (status_valid),
    .status       (status),
    .interrupt    (interrupt)
  );

  always #5 clk = ~clk;

  // First set request at or above the pointer, wrapping.
  function automatic int model_arb(input logic [N-1:0] rq, input int p);
    int sel;
    int k;
    sel = -1;
    for (int i = 0; i < N; i++) begin
      k = (p + i) % N;
      if (sel < 0 && rq[k]) sel = k;
    end
    return sel;
  endfunction

  // Cycle-level invariants while out of reset.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((start && stop) || ($countones(ack) > 1) || (status_valid !== (|ack)) ||
          (interrupt && !status_valid)) begin
        errors++;
        $display("FAIL invariant t=%0t start=%b stop=%b ack=%b sv=%b irq=%b",
                 $time, start, stop, ack, status_valid, interrupt);
      end
    end
  end

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b0; req = '0; abort = 1'b0; endd = 1'b0; er = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({start, stop, rdy, ack, status_valid, status, interrupt, gnt_id} !==
        {1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_values got st=%b sp=%b rdy=%b ack=%b sv=%b status=%0d irq=%b gnt=%0d",
               start, stop, rdy, ack, status_valid, status, interrupt, gnt_id);
    end
    rst = 1'b1;
    m_ptr = 0;
  endtask

  // One full operation, entered and left at a falling edge with the DUT idle.
  task automatic do_op(input logic [N-1:0] rq, input int kind, input int dly,
                       input bit hold, input bit junk);
    int         g;
    int         exit_r;
    bit         exp_stop;
    logic [1:0] exp_st;
    logic [1:0] exp_g;
    logic [N-1:0] exp_ack;
    g       = model_arb(rq, m_ptr);
    exp_g   = 2'(g);
    exp_ack = 4'b0001 << g;
    case (kind)
      0, 5:    begin exp_st = 2'd0; exp_stop = 1'b0; end
      1, 2, 6: begin exp_st = 2'd1; exp_stop = 1'b0; end
      3:       begin exp_st = 2'd3; exp_stop = 1'b1; end
      default: begin exp_st = 2'd2; exp_stop = 1'b1; end
    endcase
    exit_r = (kind == 4) ? T - 1 : dly;

    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL idle_rdy got %b want 1", rdy);
    end
    req = rq;
    @(negedge clk);  // START
    checks++;
    if ({start, stop, rdy, status_valid} !== 4'b1000 || gnt_id !== exp_g) begin
      errors++;
      $display("FAIL start_cycle got st/sp/rdy/sv=%b%b%b%b gnt=%0d want 1000 gnt=%0d",
               start, stop, rdy, status_valid, gnt_id, exp_g);
    end
    if (!hold) req = '0;
    if (junk) {endd, er, abort} = 3'($urandom);
    else      {endd, er, abort} = 3'b000;

    for (int r = 0; r <= exit_r; r++) begin
      @(negedge clk);  // RUN cycle r
      checks++;
      if ({start, stop, rdy, status_valid} !== 4'b0000) begin
        errors++;
        $display("FAIL run_cycle%0d got st/sp/rdy/sv=%b%b%b%b want 0000",
                 r, start, stop, rdy, status_valid);
      end
      {endd, er, abort} = 3'b000;
      if (r == exit_r) begin
        case (kind)
          0:       endd = 1'b1;
          1:       er = 1'b1;
          2:       begin endd = 1'b1; er = 1'b1; end
          3:       abort = 1'b1;
          5:       begin endd = 1'b1; abort = 1'b1; end
          6:       begin er = 1'b1; abort = 1'b1; end
          default: ;
        endcase
      end
    end

    @(negedge clk);
    if (junk) {endd, er, abort} = 3'($urandom);
    else      {endd, er, abort} = 3'b000;
    if (exp_stop) begin
      checks++;
      if ({start, stop, rdy, status_valid} !== 4'b0100) begin
        errors++;
        $display("FAIL stop_cycle got st/sp/rdy/sv=%b%b%b%b want 0100",
                 start, stop, rdy, status_valid);
      end
      @(negedge clk);
      if (junk) {endd, er, abort} = 3'($urandom);
    end

    // DONE cycle
    checks++;
    if (ack !== exp_ack || status_valid !== 1'b1 || status !== exp_st ||
        interrupt !== (exp_st != 2'd0) || {start, stop, rdy} !== 3'b000) begin
      errors++;
      $display("FAIL done_cycle got ack=%b sv=%b status=%0d irq=%b st/sp/rdy=%b%b%b want ack=%b sv=1 status=%0d irq=%b 000",
               ack, status_valid, status, interrupt, start, stop, rdy,
               exp_ack, exp_st, (exp_st != 2'd0));
    end
    {endd, er, abort} = 3'b000;
    m_ptr = (g + 1) % N;

    @(negedge clk);  // back in IDLE
    checks++;
    if ({rdy, start, ack, status_valid, interrupt} !== {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0} ||
        status !== exp_st) begin
      errors++;
      $display("FAIL after_done got rdy=%b st=%b ack=%b sv=%b irq=%b status=%0d want rdy=1 status=%0d held",
               rdy, start, ack, status_valid, interrupt, status, exp_st);
    end
  endtask

  task automatic test_reset;
    apply_reset();
  endtask

  task automatic test_basic;
    do_op(4'b0100, 0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    apply_reset();
    for (int n = 0; n < 5; n++) do_op(4'b1111, 0, 2, 1'b1, 1'b0);
    for (int n = 0; n < 3; n++) do_op(4'b0100, 0, 1, 1'b1, 1'b0);
  endtask

  task automatic test_timeout;
    do_op(4'b0001, 4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_both_results;
    do_op(4'b1000, 2, 4, 1'b0, 1'b0);
    do_op(4'b0010, 5, T - 1, 1'b0, 1'b0);
    do_op(4'b0100, 6, T - 1, 1'b0, 1'b0);
  endtask

  task automatic test_abort;
    req = '0; abort = 1'b1; endd = 1'b1; er = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rdy, start, status_valid, interrupt} !== 4'b1000) begin
        errors++;
        $display("FAIL idle_ignore got rdy/st/sv/irq=%b%b%b%b want 1000",
                 rdy, start, status_valid, interrupt);
      end
    end
    abort = 1'b0; endd = 1'b0; er = 1'b0;
    do_op(4'b0010, 3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    do_op(4'b0010, 0, 1, 1'b0, 1'b0);  // leaves pointer at 2
    req = 4'b1000;
    @(negedge clk);                     // START
    req = '0;
    repeat (2) @(negedge clk);          // two RUN cycles
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({start, stop, rdy, ack, status_valid, status, interrupt, gnt_id} !==
        {1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_async got st=%b sp=%b rdy=%b ack=%b sv=%b status=%0d irq=%b gnt=%0d",
               start, stop, rdy, ack, status_valid, status, interrupt, gnt_id);
    end
    @(negedge clk);
    checks++;
    if ({stop, ack, interrupt, rdy} !== {1'b0, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold got sp=%b ack=%b irq=%b rdy=%b", stop, ack, interrupt, rdy);
    end
    rst = 1'b1;
    m_ptr = 0;
    do_op(4'b0110, 0, 2, 1'b0, 1'b0);  // pointer back at 0 -> grant 1
  endtask

  task automatic test_random;
    logic [N-1:0] rq;
    int kind;
    int dly;
    for (int n = 0; n < 40; n++) begin
      rq   = 4'($urandom_range(15, 1));
      kind = $urandom_range(6, 0);
      dly  = $urandom_range(T - 1, 0);
      do_op(rq, kind, dly, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_both_results();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
